mont_arbiter: RTL

MONT_ARBITER -- requirements
Module: mont_arbiter

---
 rtl/mont_arbiter_if.sv | 39 +++
 rtl/mont_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mont_arbiter_if.sv
// mont_arbiter_if: requester and Montgomery-core signal bundle for mont_arbiter.
// slave = arbiter side, master = requester/core side (testbench).
interface mont_arbiter_if #(
  parameter int unsigned WIDTH = 512
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] m0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [WIDTH-1:0] m1;
  logic [1:0]       gnt;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] result;
  logic             err;
  logic             busy;
  logic             core_start;
  logic             core_resetn;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic [WIDTH-1:0] core_m;
  logic [WIDTH-1:0] core_result;
  logic             core_done;

  modport slave (
    input  req0, req1, a0, b0, m0, a1, b1, m1, core_result, core_done,
    output gnt, done0, done1, result, err, busy,
           core_start, core_resetn, core_a, core_b, core_m
  );

  modport master (
    output req0, req1, a0, b0, m0, a1, b1, m1, core_result, core_done,
    input  gnt, done0, done1, result, err, busy,
           core_start, core_resetn, core_a, core_b, core_m
  );
endinterface

// File: rtl/mont_arbiter.sv
// mont_arbiter: round-robin arbiter sharing one Montgomery multiplier core
// between two requesters. FSM: IDLE -> ISSUE -> WAIT -> CAPTURE -> RELEASE.
// Optional watchdog: define MONT_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles; the aborted done pulse is qualified by err=1.
module mont_arbiter #(
  parameter int unsigned WIDTH   = 512,
  parameter int unsigned TIMEOUT = 2048
) (
  input  logic           clk,
  input  logic           reset,
  mont_arbiter_if.slave  bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  // 1 = requester 1 was served last, so requester 0 wins a tie
  logic             last1_q, last1_d;
  logic [WIDTH-1:0] result_q, result_d;

`ifdef MONT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  // TIMEOUT only sizes the watchdog; this empty block keeps it referenced.
  if (TIMEOUT == 0) begin : g_no_watchdog
  end
`endif

  // Next-state, grant, pointer and result capture
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last1_d  = last1_q;
    result_d = result_q;
`ifdef MONT_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = ISSUE;
          if (bus.req0 && bus.req1) gnt_d = last1_q ? 2'b01 : 2'b10;
          else                      gnt_d = bus.req0 ? 2'b01 : 2'b10;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef MONT_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        // Result is captured on entry to CAPTURE so it is valid in the done cycle.
        if (bus.core_done) begin
          state_d  = CAPTURE;
          result_d = bus.core_result;
`ifdef MONT_ARB_TIMEOUT_EN
          err_d    = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = CAPTURE;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
`endif
        end
      end
      CAPTURE: begin
        state_d = RELEASE;
        gnt_d   = '0;
        last1_d = gnt_q[1];
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      last1_q  <= 1'b1;
      result_q <= '0;
`ifdef MONT_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last1_q  <= last1_d;
      result_q <= result_d;
`ifdef MONT_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Output decode from state and grant register
  always_comb begin
    bus.gnt         = gnt_q;
    bus.busy        = (state_q != IDLE);
    bus.core_start  = (state_q == ISSUE);
    bus.done0       = (state_q == CAPTURE) && gnt_q[0];
    bus.done1       = (state_q == CAPTURE) && gnt_q[1];
    bus.result      = result_q;
    bus.core_resetn = !reset && (state_q != CAPTURE);
`ifdef MONT_ARB_TIMEOUT_EN
    bus.err         = (state_q == CAPTURE) && err_q;
`else
    bus.err         = 1'b0;
`endif
    // Grant register is non-zero only from ISSUE through CAPTURE.
    case (gnt_q)
      2'b01: begin
        bus.core_a = bus.a0;
        bus.core_b = bus.b0;
        bus.core_m = bus.m0;
      end
      2'b10: begin
        bus.core_a = bus.a1;
        bus.core_b = bus.b1;
        bus.core_m = bus.m1;
      end
      default: begin
        bus.core_a = '0;
        bus.core_b = '0;
        bus.core_m = '0;
      end
    endcase
  end

endmodule
